tick_rate_controller: RTL and testbench

TICK_RATE_CONTROLLER -- requirements
Module: tick_rate_controller

---
 rtl/tick_rate_controller_if.sv | 22 ++
 rtl/tick_rate_controller.sv | 119 +++++++++++
 tb/tb_tick_rate_controller.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_rate_controller_if.sv
// Control and status bundle for the tick rate controller.
// The master drives the run, step and rate requests. The slave reports the tick and its rate status.
interface tick_rate_controller_if;
   logic       run;
   logic       step;
   logic [1:0] rate_sel;
   logic       rate_load;
   logic       tick;
   logic [1:0] rate_active;
   logic       pending;
   logic       running;

   modport master (
      output run, step, rate_sel, rate_load,
      input  tick, rate_active, pending, running
   );

   modport slave (
      input  run, step, rate_sel, rate_load,
      output tick, rate_active, pending, running
   );
endinterface

// File: rtl/tick_rate_controller.sv
// Divides clk down to 1/10/100/1000 Hz single-cycle tick enables with run, pause and single-step control.
// While running, a requested rate change waits for the current period boundary.
module tick_rate_controller #(
   parameter int         CLK_FREQ   = 50_000_000,
   parameter logic [1:0] RESET_RATE = 2'd1
) (
   input logic                   clk,
   input logic                   reset,
   tick_rate_controller_if.slave bus
);
   localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

   localparam logic [CW-1:0] LAST_0 = CW'(CLK_FREQ - 1);
   localparam logic [CW-1:0] LAST_1 = CW'(CLK_FREQ / 10 - 1);
   localparam logic [CW-1:0] LAST_2 = CW'(CLK_FREQ / 100 - 1);
   localparam logic [CW-1:0] LAST_3 = CW'(CLK_FREQ / 1000 - 1);

   typedef enum logic [1:0] {
      PAUSED,
      RUN,
      STEP
   } state_t;

   state_t        state;
   logic [CW-1:0] counter;
   logic [CW-1:0] last_count;
   logic [1:0]    rate_active_r;
   logic [1:0]    pend_rate;
   logic          pending_r;
   logic          tick_r;
   logic          running_r;
   logic          step_d;

   logic          step_edge;
   logic          wrap;
   logic          apply_req;
   logic [1:0]    apply_code;

   // A rate strobed in this very cycle takes priority over an older pending request.
   assign step_edge  = bus.step & ~step_d;
   assign wrap       = (counter == last_count);
   assign apply_req  = bus.rate_load | pending_r;
   assign apply_code = bus.rate_load ? bus.rate_sel : pend_rate;

   always_comb begin
      last_count = LAST_0;
      case (rate_active_r)
         2'd0:    last_count = LAST_0;
         2'd1:    last_count = LAST_1;
         2'd2:    last_count = LAST_2;
         default: last_count = LAST_3;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= PAUSED;
         counter       <= '0;
         rate_active_r <= RESET_RATE;
         pend_rate     <= RESET_RATE;
         pending_r     <= 1'b0;
         tick_r        <= 1'b0;
         running_r     <= 1'b0;
         step_d        <= 1'b0;
      end else begin
         step_d <= bus.step;
         tick_r <= 1'b0;
         if (bus.rate_load) begin
            pend_rate <= bus.rate_sel;
            pending_r <= 1'b1;
         end
         case (state)
            RUN: begin
               // Pausing freezes the counter so that resuming continues the same period phase.
               if (!bus.run) begin
                  state     <= PAUSED;
                  running_r <= 1'b0;
               end else if (wrap) begin
                  counter <= '0;
                  tick_r  <= 1'b1;
                  if (apply_req) begin
                     rate_active_r <= apply_code;
                     pending_r     <= 1'b0;
                  end
               end else begin
                  counter <= counter + CW'(1);
               end
            end
            STEP: begin
               if (apply_req) begin
                  rate_active_r <= apply_code;
                  pending_r     <= 1'b0;
                  counter       <= '0;
               end
               state <= PAUSED;
            end
            default: begin
               if (apply_req) begin
                  rate_active_r <= apply_code;
                  pending_r     <= 1'b0;
                  counter       <= '0;
               end
               if (bus.run) begin
                  state     <= RUN;
                  running_r <= 1'b1;
               end else if (step_edge) begin
                  state  <= STEP;
                  tick_r <= 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.tick        = tick_r;
   assign bus.rate_active = rate_active_r;
   assign bus.pending     = pending_r;
   assign bus.running     = running_r;
endmodule

// File: tb/tb_tick_rate_controller.sv
// Self-checking bench for tick_rate_controller at CLK_FREQ=1000, which gives periods of 1000/100/10/1 cycles.
// A countdown-to-next-tick reference model predicts every output on every cycle.
module tb_tick_rate_controller;
   localparam int         CLK_FREQ    = 1000;
   localparam logic [1:0] RESET_RATE  = 2'd1;
   localparam int         MODE_PAUSED = 0;
   localparam int         MODE_RUN    = 1;
   localparam int         MODE_STEP   = 2;

   logic clk;
   logic reset;

   tick_rate_controller_if bus ();

   tick_rate_controller #(
      .CLK_FREQ  (CLK_FREQ),
      .RESET_RATE(RESET_RATE)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   int   mMode;
   int   mRemain;
   int   mActive;
   int   mPendCode;
   bit   mPendFlag;
   bit   mTick;
   bit   mPrevStep;

   bit         curRun;
   bit         curStep;
   logic [1:0] curSel;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: observed %0d, expected %0d", tag, $time, observed, expected);
      end
   endtask

   function automatic int periodOf(input int code);
      return CLK_FREQ / (10 ** code);
   endfunction

   task automatic modelReset();
      mMode     = MODE_PAUSED;
      mActive   = int'(RESET_RATE);
      mPendCode = int'(RESET_RATE);
      mPendFlag = 1'b0;
      mTick     = 1'b0;
      mPrevStep = 1'b0;
      mRemain   = periodOf(mActive);
   endtask

   // mRemain counts the clock edges still needed in RUN before the next tick is issued.
   task automatic modelStep(input bit r, input bit s, input bit l, input logic [1:0] sel);
      bit rise;
      bit wantApply;
      int newCode;
      rise      = s && !mPrevStep;
      mPrevStep = s;
      wantApply = l || mPendFlag;
      newCode   = l ? int'(sel) : mPendCode;
      if (l) begin
         mPendCode = int'(sel);
         mPendFlag = 1'b1;
      end
      mTick = 1'b0;
      if (mMode == MODE_RUN) begin
         if (!r) begin
            mMode = MODE_PAUSED;
         end else begin
            mRemain--;
            if (mRemain == 0) begin
               mTick = 1'b1;
               if (wantApply) begin
                  mActive   = newCode;
                  mPendFlag = 1'b0;
               end
               mRemain = periodOf(mActive);
            end
         end
      end else begin
         if (wantApply) begin
            mActive   = newCode;
            mPendFlag = 1'b0;
            mRemain   = periodOf(mActive);
         end
         if (mMode == MODE_STEP) mMode = MODE_PAUSED;
         else if (r) mMode = MODE_RUN;
         else if (rise) begin
            mMode = MODE_STEP;
            mTick = 1'b1;
         end
      end
   endtask

   task automatic compareAll();
      checkOutput("tick", int'(bus.tick), int'(mTick));
      checkOutput("running", int'(bus.running), (mMode == MODE_RUN) ? 1 : 0);
      checkOutput("rate_active", int'(bus.rate_active), mActive);
      checkOutput("pending", int'(bus.pending), int'(mPendFlag));
   endtask

   // Called at a falling edge; drives one cycle of inputs, lets one rising edge pass and checks at the next fall.
   task automatic applyStimulus(input bit r, input bit s, input bit l, input logic [1:0] sel);
      bus.run       = r;
      bus.step      = s;
      bus.rate_load = l;
      bus.rate_sel  = sel;
      @(posedge clk);
      modelStep(r, s, l, sel);
      @(negedge clk);
      compareAll();
   endtask

   task automatic holdCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(curRun, curStep, 1'b0, curSel);
   endtask

   task automatic loadRate(input logic [1:0] sel);
      curSel = sel;
      applyStimulus(curRun, curStep, 1'b1, sel);
   endtask

   task automatic waitRemain(input int target, input int budget);
      int n;
      n = 0;
      while (mRemain != target && n < budget) begin
         holdCycles(1);
         n++;
      end
      if (mRemain != target) checkOutput("waitBudget", mRemain, target);
   endtask

   // Reset is asserted between clock edges and its effect is checked before any rising edge.
   task automatic pulseReset();
      #2 reset = 1'b0;
      #1;
      modelReset();
      compareAll();
      @(negedge clk);
      reset = 1'b1;
      compareAll();
   endtask

   initial begin
      int entry;
      int first;
      int lastTick;
      bit ld;
      logic [1:0] sel;

      reset         = 1'b0;
      bus.run       = 1'b0;
      bus.step      = 1'b0;
      bus.rate_load = 1'b0;
      bus.rate_sel  = 2'd0;
      curRun        = 1'b0;
      curStep       = 1'b0;
      curSel        = 2'd0;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      compareAll();
      reset = 1'b1;

      // Free run at 10 Hz: latency from RUN entry to first tick and steady spacing.
      curRun   = 1'b1;
      entry    = -1;
      first    = -1;
      lastTick = -1;
      for (int k = 0; k < 320; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
         if (entry < 0 && bus.running) entry = k;
         if (bus.tick) begin
            if (first < 0) first = k;
            else checkOutput("tickSpacing", k - lastTick, 100);
            lastTick = k;
         end
      end
      checkOutput("firstTickLatency", first - entry, 100);

      // Deferred change to 100 Hz requested mid-period.
      waitRemain(60, 200);
      loadRate(2'd2);
      holdCycles(120);

      // Pause mid-period, single steps, a held step, then resume.
      waitRemain(7, 20);
      curRun = 1'b0;
      holdCycles(3);
      curStep = 1'b1; holdCycles(1);
      curStep = 1'b0; holdCycles(5);
      curStep = 1'b1; holdCycles(1);
      curStep = 1'b0; holdCycles(4);
      curStep = 1'b1; holdCycles(6);
      curStep = 1'b0; holdCycles(2);
      curRun = 1'b1;
      holdCycles(40);

      // Rate load while paused, then run at the N=1 rate.
      curRun = 1'b0;
      holdCycles(2);
      loadRate(2'd3);
      holdCycles(1);
      curRun = 1'b1;
      holdCycles(20);

      // Overwritten pending request, then a load landing exactly on a wrap cycle.
      loadRate(2'd1);
      holdCycles(30);
      waitRemain(50, 200);
      loadRate(2'd0);
      holdCycles(5);
      loadRate(2'd2);
      holdCycles(60);
      waitRemain(1, 20);
      loadRate(2'd0);
      holdCycles(1010);

      // Asynchronous reset with the counter at 57.
      pulseReset();
      curRun = 1'b1;
      holdCycles(58);
      pulseReset();
      curRun = 1'b0;
      holdCycles(20);
      curRun = 1'b1;
      holdCycles(120);

      // Randomised mix of run/pause, steps, rate loads and occasional resets.
      for (int i = 0; i < 9000; i++) begin
         if ($urandom_range(199) == 0) curRun = ~curRun;
         if ($urandom_range(5) == 0) curStep = ~curStep;
         ld  = ($urandom_range(119) == 0);
         sel = 2'($urandom_range(3));
         if (ld) curSel = sel;
         if ($urandom_range(2999) == 0) pulseReset();
         applyStimulus(curRun, curStep, ld, sel);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
